// File: rtl/axi_wr_protocol_checker.sv
// Passive AXI write-path checker: tracks AW->W->B ordering, beat counts and
// VALID/payload stability, reporting the lowest violation code each cycle.
module axi_wr_protocol_checker #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      aresetn,
  input  logic [ID_W-1:0]           awid,
  input  logic [LEN_W-1:0]          awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  input  logic                      awready,
  input  logic [ID_W-1:0]           wid,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  input  logic                      wready,
  input  logic [ID_W-1:0]           bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  input  logic                      bready,
  output logic                      err_valid,
  output logic [3:0]                err_code,
  output logic [CNT_W-1:0]          err_count,
  output logic [$clog2(DEPTH):0]    wr_pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;
  localparam int SW = DATA_W / 8;

  logic [ID_W-1:0]  r_aw_id_q  [DEPTH];
  logic [LEN_W-1:0] r_aw_len_q [DEPTH];
  logic [PW-1:0]    r_aw_rd, r_aw_wr;
  logic [QW-1:0]    r_aw_cnt;
  logic [ID_W-1:0]  r_b_id_q [DEPTH];
  logic [PW-1:0]    r_b_rd, r_b_wr;
  logic [QW-1:0]    r_b_cnt;
  logic [LEN_W-1:0] r_beat;

  logic             r_aw_stall, r_w_stall, r_b_stall;
  logic [ID_W-1:0]  r_awid, r_wid, r_bid;
  logic [LEN_W-1:0] r_awlen;
  logic [2:0]       r_awsize;
  logic [1:0]       r_awburst, r_bresp;
  logic [DATA_W-1:0] r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic             r_wlast;

  logic             r_err_valid;
  logic [3:0]       r_err_code;
  logic [CNT_W-1:0] r_err_count;

  logic             w_aw_hs, w_w_hs, w_b_hs;
  logic             w_aw_empty, w_aw_full, w_b_empty, w_b_full;
  logic             w_bypass, w_has_head, w_last_beat;
  logic [ID_W-1:0]  w_head_id;
  logic [LEN_W-1:0] w_head_len;
  logic [10:1]      w_err;
  logic [3:0]       w_code;
  logic             w_aw_push, w_aw_pop, w_b_push, w_b_pop;
  logic [QW:0]      w_pend_sum;

  assign w_aw_hs    = awvalid && awready;
  assign w_w_hs     = wvalid && wready;
  assign w_b_hs     = bvalid && bready;
  assign w_aw_empty = (r_aw_cnt == '0);
  assign w_aw_full  = (r_aw_cnt == QW'(DEPTH));
  assign w_b_empty  = (r_b_cnt == '0);
  assign w_b_full   = (r_b_cnt == QW'(DEPTH));

  // An address arriving alongside the first beat of an idle queue supplies the head directly.
  assign w_bypass    = w_w_hs && w_aw_hs && w_aw_empty;
  assign w_has_head  = w_w_hs && (!w_aw_empty || w_aw_hs);
  assign w_head_id   = w_bypass ? awid  : r_aw_id_q[r_aw_rd];
  assign w_head_len  = w_bypass ? awlen : r_aw_len_q[r_aw_rd];
  assign w_last_beat = (r_beat == w_head_len);

  assign w_err[1]  = r_aw_stall && (!awvalid || awid != r_awid || awlen != r_awlen ||
                                    awsize != r_awsize || awburst != r_awburst);
  assign w_err[2]  = r_w_stall && (!wvalid || wid != r_wid || wdata != r_wdata ||
                                   wstrb != r_wstrb || wlast != r_wlast);
  assign w_err[3]  = r_b_stall && (!bvalid || bid != r_bid || bresp != r_bresp);
  assign w_err[4]  = w_aw_hs && (awburst == 2'b11);
  assign w_err[5]  = w_w_hs && !w_has_head;
  assign w_err[6]  = w_has_head && (wlast != w_last_beat);
  assign w_err[7]  = w_has_head && (wid != w_head_id);
  assign w_err[8]  = bvalid && w_b_empty;
  assign w_err[9]  = w_b_hs && !w_b_empty && (bid != r_b_id_q[r_b_rd]);
  assign w_err[10] = w_aw_hs && w_aw_full;

  always_comb begin
    w_code = '0;
    for (int i = 10; i >= 1; i--) begin
      if (w_err[i]) w_code = 4'(i);
    end
  end

  assign w_aw_push = w_aw_hs && !w_aw_full && !(w_bypass && wlast);
  assign w_aw_pop  = w_has_head && wlast && !w_bypass;
  assign w_b_push  = w_has_head && wlast && !w_b_full;
  assign w_b_pop   = w_b_hs && !w_b_empty;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_aw_id_q[i]  <= '0;
        r_aw_len_q[i] <= '0;
        r_b_id_q[i]   <= '0;
      end
      r_aw_rd     <= '0;
      r_aw_wr     <= '0;
      r_aw_cnt    <= '0;
      r_b_rd      <= '0;
      r_b_wr      <= '0;
      r_b_cnt     <= '0;
      r_beat      <= '0;
      r_aw_stall  <= 1'b0;
      r_w_stall   <= 1'b0;
      r_b_stall   <= 1'b0;
      r_awid      <= '0;
      r_awlen     <= '0;
      r_awsize    <= '0;
      r_awburst   <= '0;
      r_wid       <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wlast     <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_err_count <= '0;
    end else begin
      if (w_aw_push) begin
        r_aw_id_q[r_aw_wr]  <= awid;
        r_aw_len_q[r_aw_wr] <= awlen;
        r_aw_wr             <= r_aw_wr + PW'(1);
      end
      if (w_aw_pop) r_aw_rd <= r_aw_rd + PW'(1);
      r_aw_cnt <= r_aw_cnt + QW'(w_aw_push) - QW'(w_aw_pop);

      if (w_b_push) begin
        r_b_id_q[r_b_wr] <= w_head_id;
        r_b_wr           <= r_b_wr + PW'(1);
      end
      if (w_b_pop) r_b_rd <= r_b_rd + PW'(1);
      r_b_cnt <= r_b_cnt + QW'(w_b_push) - QW'(w_b_pop);

      // A short wlast still retires the burst; a missing wlast parks on the final beat.
      if (w_has_head) begin
        if (wlast)             r_beat <= '0;
        else if (!w_last_beat) r_beat <= r_beat + LEN_W'(1);
      end

      r_aw_stall <= awvalid && !awready;
      r_w_stall  <= wvalid && !wready;
      r_b_stall  <= bvalid && !bready;
      r_awid     <= awid;
      r_awlen    <= awlen;
      r_awsize   <= awsize;
      r_awburst  <= awburst;
      r_wid      <= wid;
      r_wdata    <= wdata;
      r_wstrb    <= wstrb;
      r_wlast    <= wlast;
      r_bid      <= bid;
      r_bresp    <= bresp;

      if (w_err != '0) begin
        r_err_valid <= 1'b1;
        r_err_code  <= w_code;
        if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
      end else begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign w_pend_sum = {1'b0, r_aw_cnt} + {1'b0, r_b_cnt};
  assign wr_pending = w_pend_sum[QW] ? '1 : w_pend_sum[QW-1:0];
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;
  assign err_count  = r_err_count;
endmodule

// File: tb/tb_axi_wr_protocol_checker.sv
// Bench for axi_wr_protocol_checker: queue-based reference model checked every
// cycle, with directed scenarios pinning literal outcomes and a random soak.
module tb_axi_wr_protocol_checker;
  localparam int ID_W = 4, DATA_W = 32, LEN_W = 8, DEPTH = 8, CNT_W = 4;
  localparam int PEND_MAX = 2 ** ($clog2(DEPTH) + 1) - 1;
  localparam int CNT_MAX  = 2 ** CNT_W - 1;

  logic clock = 1'b0;
  logic aresetn;
  logic [ID_W-1:0] awid, wid, bid;
  logic [LEN_W-1:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic err_valid;
  logic [3:0] err_code;
  logic [CNT_W-1:0] err_count;
  logic [$clog2(DEPTH):0] wr_pending;

  int n_checks = 0;
  int n_fail = 0;

  axi_wr_protocol_checker #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                            .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .aresetn(aresetn),
    .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count),
    .wr_pending(wr_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: plain queues of outstanding bursts and completed IDs.
  logic [ID_W-1:0]  m_aw_id[$];
  logic [LEN_W-1:0] m_aw_len[$];
  logic [ID_W-1:0]  m_b[$];
  int m_beat;
  bit m_pv;
  logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_wlast;
  logic [ID_W-1:0] p_awid, p_wid, p_bid;
  logic [LEN_W-1:0] p_awlen;
  logic [2:0] p_awsize;
  logic [1:0] p_awburst, p_bresp;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W/8-1:0] p_wstrb;
  int exp_valid, exp_code, exp_count, exp_pend;

  task automatic model_step();
    logic [10:1] e;
    bit aw_hs, w_hs, b_hs, byp, has_head, last_beat, b_room;
    logic [ID_W-1:0] hid;
    logic [LEN_W-1:0] hlen;
    if (!aresetn) begin
      m_aw_id.delete(); m_aw_len.delete(); m_b.delete();
      m_beat = 0; m_pv = 0;
      exp_valid = 0; exp_code = 0; exp_count = 0; exp_pend = 0;
      return;
    end
    e = '0;
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    b_hs  = bvalid && bready;
    if (m_pv && p_awv && !p_awr && (!awvalid || awid != p_awid || awlen != p_awlen ||
        awsize != p_awsize || awburst != p_awburst)) e[1] = 1;
    if (m_pv && p_wv && !p_wr && (!wvalid || wid != p_wid || wdata != p_wdata ||
        wstrb != p_wstrb || wlast != p_wlast)) e[2] = 1;
    if (m_pv && p_bv && !p_br && (!bvalid || bid != p_bid || bresp != p_bresp)) e[3] = 1;
    e[4] = aw_hs && awburst == 2'b11;
    byp = w_hs && aw_hs && m_aw_id.size() == 0;
    has_head = w_hs && (m_aw_id.size() != 0 || byp);
    e[5] = w_hs && !has_head;
    hid = '0; hlen = '0; last_beat = 0;
    if (has_head) begin
      hid  = byp ? awid : m_aw_id[0];
      hlen = byp ? awlen : m_aw_len[0];
      last_beat = (m_beat == int'(hlen));
      e[6] = (wlast != last_beat);
      e[7] = (wid != hid);
    end
    e[8] = bvalid && m_b.size() == 0;
    e[9] = b_hs && m_b.size() != 0 && bid != m_b[0];
    e[10] = aw_hs && m_aw_id.size() == DEPTH;

    b_room = m_b.size() < DEPTH;
    if (b_hs && m_b.size() != 0) void'(m_b.pop_front());
    if (aw_hs && !e[10] && !(byp && wlast)) begin
      m_aw_id.push_back(awid);
      m_aw_len.push_back(awlen);
    end
    if (has_head) begin
      if (wlast) begin
        if (!byp) begin
          void'(m_aw_id.pop_front());
          void'(m_aw_len.pop_front());
        end
        if (b_room) m_b.push_back(hid);
        m_beat = 0;
      end else if (!last_beat) begin
        m_beat++;
      end
    end

    if (e != 0) begin
      exp_valid = 1;
      for (int i = 10; i >= 1; i--) if (e[i]) exp_code = i;
      if (exp_count < CNT_MAX) exp_count++;
    end else begin
      exp_valid = 0;
    end
    exp_pend = m_aw_id.size() + m_b.size();
    if (exp_pend > PEND_MAX) exp_pend = PEND_MAX;

    m_pv = 1;
    p_awv = awvalid; p_awr = awready; p_awid = awid; p_awlen = awlen;
    p_awsize = awsize; p_awburst = awburst;
    p_wv = wvalid; p_wr = wready; p_wid = wid; p_wdata = wdata; p_wstrb = wstrb; p_wlast = wlast;
    p_bv = bvalid; p_br = bready; p_bid = bid; p_bresp = bresp;
  endtask

  always @(posedge clock) begin
    model_step();
    #1;
    check("mdl_err_valid", int'(err_valid), exp_valid);
    check("mdl_err_code", int'(err_code), exp_code);
    check("mdl_err_count", int'(err_count), exp_count);
    check("mdl_wr_pending", int'(wr_pending), exp_pend);
  end

  task automatic idle_inputs();
    awvalid = 0; awready = 0; awid = '0; awlen = '0; awsize = '0; awburst = 2'd1;
    wvalid = 0; wready = 0; wid = '0; wdata = '0; wstrb = '0; wlast = 0;
    bvalid = 0; bready = 0; bid = '0; bresp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    repeat (2) @(negedge clock);
    aresetn = 1;
    @(negedge clock);
  endtask

  task automatic aw_hs(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                       input logic [1:0] burst);
    awvalid = 1; awready = 1; awid = id; awlen = len; awsize = 3'd2; awburst = burst;
    @(negedge clock);
    awvalid = 0; awready = 0;
  endtask

  task automatic w_hs(input logic [ID_W-1:0] id, input logic last);
    wvalid = 1; wready = 1; wid = id; wdata = $urandom; wstrb = 4'hf; wlast = last;
    @(negedge clock);
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic b_hs(input logic [ID_W-1:0] id);
    bvalid = 1; bready = 1; bid = id; bresp = 2'b00;
    @(negedge clock);
    bvalid = 0; bready = 0;
  endtask

  task automatic rand_drive();
    if (awvalid && !awready && $urandom_range(9) != 0) begin
      awready = 1'($urandom_range(1));
    end else begin
      awvalid = 1'($urandom_range(1));
      awready = ($urandom_range(9) < 6);
      awid    = 4'($urandom_range(1));
      awlen   = 8'($urandom_range(2));
      awsize  = 3'($urandom_range(2));
      awburst = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2));
    end
    if (wvalid && !wready && $urandom_range(9) != 0) begin
      wready = 1'($urandom_range(1));
    end else begin
      wvalid = ($urandom_range(9) < 6);
      wready = ($urandom_range(9) < 7);
      wid    = 4'($urandom_range(1));
      wdata  = $urandom;
      wstrb  = 4'($urandom);
      wlast  = ($urandom_range(2) == 0);
    end
    if (bvalid && !bready && $urandom_range(9) != 0) begin
      bready = 1'($urandom_range(1));
    end else begin
      bvalid = ($urandom_range(9) < 4);
      bready = ($urandom_range(9) < 7);
      bid    = 4'($urandom_range(1));
      bresp  = 2'($urandom);
    end
  endtask

  initial begin
    idle_inputs();
    aresetn = 0;
    repeat (2) @(negedge clock);
    check("reset_err_valid", int'(err_valid), 0);
    check("reset_err_code", int'(err_code), 0);
    check("reset_err_count", int'(err_count), 0);
    check("reset_wr_pending", int'(wr_pending), 0);
    aresetn = 1;
    @(negedge clock);

    // Clean 4-beat burst.
    aw_hs(4'd1, 8'd3, 2'd1);
    check("clean_pending_aw", int'(wr_pending), 1);
    for (int i = 0; i < 4; i++) w_hs(4'd1, i == 3);
    check("clean_pending_w", int'(wr_pending), 1);
    b_hs(4'd1);
    check("clean_pending_b", int'(wr_pending), 0);
    check("clean_err_count", int'(err_count), 0);

    // AW payload change while stalled.
    do_reset();
    awvalid = 1; awready = 0; awid = 4'd0; awlen = 8'd3; awburst = 2'd1;
    @(negedge clock);
    awlen = 8'd5;
    @(negedge clock);
    check("aw_unstable_valid", int'(err_valid), 1);
    check("aw_unstable_code", int'(err_code), 1);
    check("aw_unstable_count", int'(err_count), 1);
    awready = 1;
    @(negedge clock);
    awvalid = 0; awready = 0;
    check("aw_accept_clean", int'(err_valid), 0);

    // Early wlast, then a clean burst.
    do_reset();
    aw_hs(4'd3, 8'd1, 2'd1);
    w_hs(4'd3, 1'b1);
    check("early_last_valid", int'(err_valid), 1);
    check("early_last_code", int'(err_code), 6);
    aw_hs(4'd3, 8'd1, 2'd1);
    w_hs(4'd3, 1'b0);
    check("after_early_b0", int'(err_valid), 0);
    w_hs(4'd3, 1'b1);
    check("after_early_b1", int'(err_valid), 0);
    check("after_early_count", int'(err_count), 1);
    check("after_early_pending", int'(wr_pending), 2);

    // AW overflow.
    do_reset();
    for (int i = 0; i < 9; i++) aw_hs(4'(i), 8'd0, 2'd0);
    check("ovf_valid", int'(err_valid), 1);
    check("ovf_code", int'(err_code), 10);
    check("ovf_pending", int'(wr_pending), 8);
    check("ovf_count", int'(err_count), 1);

    // Out-of-order B, then B with nothing complete.
    do_reset();
    aw_hs(4'd2, 8'd0, 2'd1);
    aw_hs(4'd5, 8'd0, 2'd1);
    w_hs(4'd2, 1'b1);
    w_hs(4'd5, 1'b1);
    check("b_order_pre", int'(err_valid), 0);
    b_hs(4'd5);
    check("b_order_code", int'(err_code), 9);
    check("b_order_pending", int'(wr_pending), 1);
    b_hs(4'd5);
    check("b_second_clean", int'(err_valid), 0);
    b_hs(4'd0);
    check("b_empty_code", int'(err_code), 8);
    check("b_empty_count", int'(err_count), 2);

    // Counter saturation.
    do_reset();
    bvalid = 1; bready = 0; bid = 4'd0;
    repeat (20) @(negedge clock);
    check("sat_count", int'(err_count), 15);
    check("sat_code", int'(err_code), 8);

    // Reset mid-burst.
    do_reset();
    aw_hs(4'd1, 8'd3, 2'b11);
    w_hs(4'd1, 1'b0);
    check("mid_pre_count", int'(err_count), 1);
    #2 aresetn = 0;
    #1;
    check("mid_rst_valid", int'(err_valid), 0);
    check("mid_rst_count", int'(err_count), 0);
    check("mid_rst_pending", int'(wr_pending), 0);
    @(negedge clock);
    aresetn = 1;
    repeat (3) @(negedge clock);
    check("mid_rst_quiet", int'(err_valid), 0);

    // Random soak with occasional asynchronous resets.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 300 == 299) begin
        #2 aresetn = 0;
        @(negedge clock);
        @(negedge clock);
        aresetn = 1;
      end else begin
        rand_drive();
        @(negedge clock);
      end
    end

    idle_inputs();
    @(negedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
